// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire membrane stage.
package lif_pkg;

    localparam int unsigned DEFAULT_V_W      = 32;
    localparam int unsigned DEFAULT_REFRAC_W = 4;

    localparam logic signed [DEFAULT_V_W-1:0] V_MAX = {1'b0, {(DEFAULT_V_W-1){1'b1}}};
    localparam logic signed [DEFAULT_V_W-1:0] V_MIN = {1'b1, {(DEFAULT_V_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_LEAK,
        ST_FIRE,
        ST_OUT
    } lif_state_e;

endpackage

// File: rtl/lif_sat_add.sv
// Signed adder for the membrane datapath; saturates when LIF_SATURATE_EN is
// defined, otherwise wraps in two's complement.
module lif_sat_add
    import lif_pkg::*;
#(
    parameter int unsigned W = DEFAULT_V_W
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

`ifdef LIF_SATURATE_EN
    logic signed [W:0] sum_ext;

    assign sum_ext = {a[W-1], a} + {b[W-1], b};

    // Overflow shows up as disagreement between the guard bit and the sign bit.
    always_comb begin
        if (sum_ext[W] != sum_ext[W-1]) begin
            y = sum_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = sum_ext[W-1:0];
        end
    end
`else
    assign y = a + b;
`endif

endmodule

// File: rtl/lif_potential_unit.sv
// LIF membrane stage: accumulates MAC results, applies leak/threshold/refractory
// at each timestep boundary and emits one spike record per timestep.
// Optional saturation of the datapath: define LIF_SATURATE_EN.
module lif_potential_unit
    import lif_pkg::*;
#(
    parameter int unsigned V_W      = DEFAULT_V_W,
    parameter int unsigned REFRAC_W = DEFAULT_REFRAC_W
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    mac_valid,
    output logic                    mac_ready,
    input  logic signed [V_W-1:0]   mac_result,
    input  logic                    timestep_end,
    input  logic signed [V_W-1:0]   v_threshold,
    input  logic signed [V_W-1:0]   v_reset,
    input  logic        [4:0]       leak_shift,
    input  logic        [REFRAC_W-1:0] refrac_period,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_spike,
    output logic signed [V_W-1:0]   v_mem,
    output logic                    overrun
);

    lif_state_e state_q, state_d;

    logic signed [V_W-1:0]      v_q, v_d;
    logic        [REFRAC_W-1:0] refrac_q, refrac_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_spike_q, out_spike_d;
    logic                       pending_q, pending_d;
    logic                       overrun_q, overrun_d;

    logic signed [V_W-1:0] acc_sum;
    logic signed [V_W-1:0] leak_neg;
    logic signed [V_W-1:0] leak_sum;

    // Negating v >>> s (s >= 1) cannot overflow, so the leak reuses the adder.
    assign leak_neg = -(v_q >>> leak_shift);

    lif_sat_add #(.W(V_W)) u_acc_add (
        .a (v_q),
        .b (mac_result),
        .y (acc_sum)
    );

    lif_sat_add #(.W(V_W)) u_leak_add (
        .a (v_q),
        .b (leak_neg),
        .y (leak_sum)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (timestep_end || pending_q) state_d = ST_LEAK;
            ST_LEAK:  state_d = ST_FIRE;
            ST_FIRE:  state_d = ST_OUT;
            ST_OUT:   if (out_ready) state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        v_d         = v_q;
        refrac_d    = refrac_q;
        out_valid_d = out_valid_q;
        out_spike_d = out_spike_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;

        case (state_q)
            ST_ACCUM: begin
                if (mac_valid && (refrac_q == '0)) v_d = acc_sum;
                // A stored boundary is consumed now; a fresh pulse in the same cycle stays queued.
                pending_d = pending_q & timestep_end;
            end
            ST_LEAK: begin
                if ((refrac_q == '0) && (leak_shift != '0)) v_d = leak_sum;
            end
            ST_FIRE: begin
                out_valid_d = 1'b1;
                if (refrac_q != '0) begin
                    refrac_d    = refrac_q - REFRAC_W'(1);
                    v_d         = v_reset;
                    out_spike_d = 1'b0;
                end else if (v_q >= v_threshold) begin
                    out_spike_d = 1'b1;
                    v_d         = v_reset;
                    refrac_d    = refrac_period;
                end else begin
                    out_spike_d = 1'b0;
                end
            end
            ST_OUT: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase

        if ((state_q != ST_ACCUM) && timestep_end) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            v_q         <= '0;
            refrac_q    <= '0;
            out_valid_q <= 1'b0;
            out_spike_q <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            v_q         <= v_d;
            refrac_q    <= refrac_d;
            out_valid_q <= out_valid_d;
            out_spike_q <= out_spike_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mac_ready = (state_q == ST_ACCUM);
    assign out_valid = out_valid_q;
    assign out_spike = out_spike_q;
    assign v_mem     = v_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_lif_potential_unit.sv
// Directed plus randomized bench for lif_potential_unit against a timestep-level
// behavioural model of the neuron.
module tb_lif_potential_unit;

    logic               CLK = 1'b0;
    logic               RESET_N;
    logic               mac_valid;
    logic               mac_ready;
    logic signed [31:0] mac_result;
    logic               timestep_end;
    logic signed [31:0] v_threshold;
    logic signed [31:0] v_reset;
    logic        [4:0]  leak_shift;
    logic        [3:0]  refrac_period;
    logic               out_valid;
    logic               out_ready;
    logic               out_spike;
    logic signed [31:0] v_mem;
    logic               overrun;

    int n_asserts = 0;
    int n_fail    = 0;

    longint m_v;
    int     m_ref;
    longint m_thr;
    longint m_vrst;
    int     m_ls;
    int     m_rp;

    always #5 CLK = ~CLK;

    lif_potential_unit #(.V_W(32), .REFRAC_W(4)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .mac_valid     (mac_valid),
        .mac_ready     (mac_ready),
        .mac_result    (mac_result),
        .timestep_end  (timestep_end),
        .v_threshold   (v_threshold),
        .v_reset       (v_reset),
        .leak_shift    (leak_shift),
        .refrac_period (refrac_period),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_spike     (out_spike),
        .v_mem         (v_mem),
        .overrun       (overrun)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint norm(input longint x);
`ifdef LIF_SATURATE_EN
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
`else
        logic signed [31:0] lo;
        lo = x[31:0];
        return lo;
`endif
    endfunction

    function automatic void model_mac(input longint m);
        if (m_ref == 0) m_v = norm(m_v + m);
    endfunction

    function automatic bit model_step();
        bit spk;
        if (m_ref == 0 && m_ls != 0) m_v = norm(m_v - (m_v >>> m_ls));
        if (m_ref != 0) begin
            m_ref--;
            m_v = m_vrst;
            spk = 1'b0;
        end else if (m_v >= m_thr) begin
            spk   = 1'b1;
            m_v   = m_vrst;
            m_ref = m_rp;
        end else begin
            spk = 1'b0;
        end
        return spk;
    endfunction

    task automatic set_params(input longint thr, input longint vrst, input int ls, input int rp);
        @(negedge CLK);
        m_thr = thr; m_vrst = vrst; m_ls = ls; m_rp = rp;
        v_threshold   = 32'(thr);
        v_reset       = 32'(vrst);
        leak_shift    = 5'(ls);
        refrac_period = 4'(rp);
    endtask

    task automatic do_mac(input longint m, input string tag);
        @(negedge CLK);
        check($sformatf("%s.ready", tag), longint'(mac_ready), 1);
        mac_valid  = 1'b1;
        mac_result = 32'(m);
        model_mac(m);
        @(posedge CLK); #1;
        mac_valid = 1'b0;
        check($sformatf("%s.v", tag), longint'(v_mem), m_v);
    endtask

    task automatic timestep(input bit with_mac, input longint m, input string tag);
        bit exp_spk;
        @(negedge CLK);
        timestep_end = 1'b1;
        if (with_mac) begin
            mac_valid  = 1'b1;
            mac_result = 32'(m);
            model_mac(m);
        end
        @(negedge CLK);
        timestep_end = 1'b0;
        mac_valid    = 1'b0;
        exp_spk = model_step();
        @(posedge CLK); #1;
        check($sformatf("%s.valid_early", tag), longint'(out_valid), 0);
        @(posedge CLK); #1;
        check($sformatf("%s.valid", tag), longint'(out_valid), 1);
        check($sformatf("%s.spike", tag), longint'(out_spike), longint'(exp_spk));
        check($sformatf("%s.v", tag), longint'(v_mem), m_v);
        check($sformatf("%s.ready_busy", tag), longint'(mac_ready), 0);
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        check($sformatf("%s.valid_done", tag), longint'(out_valid), 0);
        check($sformatf("%s.ready_back", tag), longint'(mac_ready), 1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        check(tag, longint'(out_valid), 1);
    endtask

    initial begin
        bit     spk_a, spk_b, held_spk;
        longint exp_sat;

        RESET_N = 1'b0;
        mac_valid = 1'b0; mac_result = '0; timestep_end = 1'b0; out_ready = 1'b0;
        v_threshold = '0; v_reset = '0; leak_shift = '0; refrac_period = '0;
        m_v = 0; m_ref = 0; m_thr = 0; m_vrst = 0; m_ls = 0; m_rp = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst.valid", longint'(out_valid), 0);
        check("rst.spike", longint'(out_spike), 0);
        check("rst.v", longint'(v_mem), 0);
        check("rst.overrun", longint'(overrun), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        check("rst.ready", longint'(mac_ready), 1);

        // Plain integrate and fire
        set_params(100, 0, 0, 0);
        do_mac(40, "t1.m0");
        do_mac(40, "t1.m1");
        do_mac(30, "t1.m2");
        check("t1.v110", longint'(v_mem), 110);
        timestep(1'b0, 0, "t1");
        check("t1.fired_v", longint'(v_mem), 0);

        // Leak by halves
        set_params(1000, 0, 1, 0);
        do_mac(64, "t2.m");
        timestep(1'b0, 0, "t2a");
        check("t2a.v32", longint'(v_mem), 32);
        timestep(1'b0, 0, "t2b");
        check("t2b.v16", longint'(v_mem), 16);

        // Refractory silencing
        set_params(100, 0, 0, 2);
        do_mac(200, "t3.m0");
        timestep(1'b0, 0, "t3.fire0");
        do_mac(500, "t3.m1");
        timestep(1'b0, 0, "t3.ref1");
        do_mac(500, "t3.m2");
        timestep(1'b0, 0, "t3.ref2");
        do_mac(500, "t3.m3");
        timestep(1'b0, 0, "t3.fire1");
        set_params(100, 0, 0, 0);
        timestep(1'b0, 0, "t3.drain0");
        timestep(1'b0, 0, "t3.drain1");

        // Overflow boundary: saturate or wrap
        set_params(64'sd2147483647, 0, 0, 0);
        do_mac(64'h7FFFFFF0, "t4.m0");
        do_mac(64'h100, "t4.m1");
`ifdef LIF_SATURATE_EN
        exp_sat = 64'sd2147483647;
`else
        exp_sat = -64'sd2147483408;
`endif
        check("t4.boundary", longint'(v_mem), exp_sat);
        timestep(1'b0, 0, "t4.ts");

        // Randomized timesteps, including a MAC coincident with the boundary
        for (int i = 0; i < 25; i++) begin
            int nm;
            set_params(longint'(int'($urandom_range(400))), longint'(int'($urandom_range(40)) - 20),
                       int'($urandom_range(3)), int'($urandom_range(2)));
            nm = int'($urandom_range(3));
            for (int k = 0; k < nm; k++) begin
                do_mac(longint'(int'($urandom_range(600)) - 300), $sformatf("rnd%0d.m%0d", i, k));
            end
            timestep(bit'($urandom_range(1)), longint'(int'($urandom_range(600)) - 300),
                     $sformatf("rnd%0d", i));
        end

        // Backpressure with two boundaries arriving while the record is held
        set_params(1000, 0, 0, 0);
        do_mac(50, "t5.m");
        @(negedge CLK);
        timestep_end = 1'b1;
        @(negedge CLK);
        timestep_end = 1'b0;
        spk_a = model_step();
        @(posedge CLK); #1;
        wait_valid("t5.valid");
        held_spk = out_spike;
        check("t5.spike", longint'(out_spike), longint'(spk_a));
        check("t5.v", longint'(v_mem), m_v);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            timestep_end = (c == 1 || c == 3);
            @(posedge CLK); #1;
            check($sformatf("t5.hold_valid%0d", c), longint'(out_valid), 1);
            check($sformatf("t5.hold_spike%0d", c), longint'(out_spike), longint'(held_spk));
            check($sformatf("t5.hold_ready%0d", c), longint'(mac_ready), 0);
        end
        @(negedge CLK);
        timestep_end = 1'b0;
        check("t5.overrun", longint'(overrun), 1);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        check("t5.released", longint'(out_valid), 0);
        spk_b = model_step();
        @(posedge CLK); #1;
        wait_valid("t5.pend_valid");
        check("t5.pend_spike", longint'(out_spike), longint'(spk_b));
        check("t5.pend_v", longint'(v_mem), m_v);
        check("t5.overrun_sticky", longint'(overrun), 1);

        // Asynchronous reset while a record is held
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check("t6.valid", longint'(out_valid), 0);
        check("t6.spike", longint'(out_spike), 0);
        check("t6.v", longint'(v_mem), 0);
        check("t6.ready", longint'(mac_ready), 1);
        check("t6.overrun", longint'(overrun), 0);
        m_v = 0; m_ref = 0;
        @(negedge CLK);
        RESET_N = 1'b1;
        do_mac(77, "t6.after");
        timestep(1'b0, 0, "t6.ts");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
